// File: rtl/yazmac_yazma_hakemi_pkg.sv
// Shared widths, arbiter state encoding and the buffered write entry type
// for the register-file write arbiter.
package yazmac_yazma_hakemi_pkg;

  localparam int VERI_BIT    = 32;
  localparam int YAZMAC_BIT  = 5;
  localparam int UOP_TAG_BIT = 6;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic {
    NORMAL = 1'b0,
    DURDUR = 1'b1
  } hakem_durum_e;

  typedef struct packed {
    logic [VERI_BIT-1:0]    veri;
    logic [YAZMAC_BIT-1:0]  adres;
    logic [UOP_TAG_BIT-1:0] etiket;
  } yazma_girdisi_t;

  function automatic logic [3:0] doygun_artir(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/yazmac_yazma_hakemi_if.sv
// Writeback, multi-cycle result and register-file write port signals.
interface yazmac_yazma_hakemi_if;
  import yazmac_yazma_hakemi_pkg::*;

  logic                   gy_gecerli_i;
  logic [VERI_BIT-1:0]    gy_veri_i;
  logic [YAZMAC_BIT-1:0]  gy_adres_i;
  logic [UOP_TAG_BIT-1:0] gy_etiket_i;

  logic                   cb_gecerli_i;
  logic [VERI_BIT-1:0]    cb_veri_i;
  logic [YAZMAC_BIT-1:0]  cb_adres_i;
  logic [UOP_TAG_BIT-1:0] cb_etiket_i;
  logic                   cb_hazir_o;

  logic                   boru_durdur_o;

  logic                   yo_gecerli_o;
  logic [VERI_BIT-1:0]    yo_veri_o;
  logic [YAZMAC_BIT-1:0]  yo_adres_o;
  logic [UOP_TAG_BIT-1:0] yo_etiket_o;
  logic                   yo_kaynak_o;

  modport master (
    output gy_gecerli_i, gy_veri_i, gy_adres_i, gy_etiket_i,
    output cb_gecerli_i, cb_veri_i, cb_adres_i, cb_etiket_i,
    input  cb_hazir_o, boru_durdur_o,
    input  yo_gecerli_o, yo_veri_o, yo_adres_o, yo_etiket_o, yo_kaynak_o
  );

  modport slave (
    input  gy_gecerli_i, gy_veri_i, gy_adres_i, gy_etiket_i,
    input  cb_gecerli_i, cb_veri_i, cb_adres_i, cb_etiket_i,
    output cb_hazir_o, boru_durdur_o,
    output yo_gecerli_o, yo_veri_o, yo_adres_o, yo_etiket_o, yo_kaynak_o
  );
endinterface

// File: rtl/yazmac_yazma_hakemi_yazma_tamponu.sv
// Two-entry FIFO holding multi-cycle unit results until the write port is granted.
module yazma_tamponu
  import yazmac_yazma_hakemi_pkg::*;
(
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           it,
  input  yazma_girdisi_t it_girdi,
  input  logic           cek,
  output yazma_girdisi_t bas,
  output logic [1:0]     sayi
);

  yazma_girdisi_t mem [2];
  logic           yaz_ptr;
  logic           oku_ptr;
  logic           it_gecerli;
  logic           cek_gecerli;

  // A full buffer refuses pushes even when the head leaves in the same cycle.
  assign it_gecerli  = it && (sayi != 2'd2);
  assign cek_gecerli = cek && (sayi != 2'd0);
  assign bas         = mem[oku_ptr];

  always_ff @(posedge clk_i) begin
    if (it_gecerli) begin
      mem[yaz_ptr] <= it_girdi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      yaz_ptr <= LOW;
      oku_ptr <= LOW;
      sayi    <= 2'd0;
    end else begin
      if (it_gecerli)  yaz_ptr <= ~yaz_ptr;
      if (cek_gecerli) oku_ptr <= ~oku_ptr;
      case ({it_gecerli, cek_gecerli})
        2'b10:   sayi <= sayi + 2'd1;
        2'b01:   sayi <= sayi - 2'd1;
        default: sayi <= sayi;
      endcase
    end
  end

endmodule

// File: rtl/yazmac_yazma_hakemi.sv
// Register-file write port arbiter: pipeline writeback vs buffered multi-cycle results.
//   state  | meaning
//   NORMAL | pipeline has priority, buffer head written when pipeline is idle
//   DURDUR | pipeline stalled for one cycle, buffer head is written
module yazmac_yazma_hakemi
  import yazmac_yazma_hakemi_pkg::*;
#(
  parameter int ESIK = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  yazmac_yazma_hakemi_if.slave  bus
);

  localparam logic [4:0] ESIK_5 = 5'(ESIK);

  hakem_durum_e   durum_q, durum_d;
  logic [3:0]     sayac_q, sayac_d;
  logic [1:0]     sayi;
  yazma_girdisi_t bas;
  yazma_girdisi_t cb_girdi;
  yazma_girdisi_t gy_girdi;
  yazma_girdisi_t yo_q;
  logic           yo_gecerli_q;
  logic           yo_kaynak_q;
  logic           gy_ok;
  logic           cb_it;
  logic           gy_kazan;
  logic           bas_kazan;

  assign gy_girdi = '{veri: bus.gy_veri_i, adres: bus.gy_adres_i, etiket: bus.gy_etiket_i};
  assign cb_girdi = '{veri: bus.cb_veri_i, adres: bus.cb_adres_i, etiket: bus.cb_etiket_i};

  // Writes to x0 are dropped at the inputs; the cb handshake still completes.
  assign gy_ok = bus.gy_gecerli_i && (bus.gy_adres_i != '0);
  assign cb_it = bus.cb_gecerli_i && bus.cb_hazir_o && (bus.cb_adres_i != '0);

  assign bus.cb_hazir_o    = (sayi != 2'd2) && rstn_i;
  assign bus.boru_durdur_o = (durum_q == DURDUR);

  yazma_tamponu u_tampon (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .it       (cb_it),
    .it_girdi (cb_girdi),
    .cek      (bas_kazan),
    .bas      (bas),
    .sayi     (sayi)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      durum_q <= NORMAL;
      sayac_q <= 4'd0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
    end
  end

  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    gy_kazan  = LOW;
    bas_kazan = LOW;
    if (durum_q == DURDUR) begin
      bas_kazan = (sayi != 2'd0);
      durum_d   = NORMAL;
    end else if (gy_ok) begin
      gy_kazan = HIGH;
    end else if (sayi != 2'd0) begin
      bas_kazan = HIGH;
    end
    if ((sayi == 2'd0) || bas_kazan) begin
      sayac_d = 4'd0;
    end else begin
      sayac_d = doygun_artir(sayac_q);
    end
    // The stall is decided on the increment that would reach the threshold.
    if ((durum_q == NORMAL) && (sayi != 2'd0) && !bas_kazan &&
        (({1'b0, sayac_q} + 5'd1) >= ESIK_5)) begin
      durum_d = DURDUR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      yo_gecerli_q <= LOW;
      yo_kaynak_q  <= LOW;
      yo_q         <= '0;
    end else if (gy_kazan || bas_kazan) begin
      yo_gecerli_q <= HIGH;
      yo_kaynak_q  <= bas_kazan;
      yo_q         <= bas_kazan ? bas : gy_girdi;
    end else begin
      yo_gecerli_q <= LOW;
    end
  end

  assign bus.yo_gecerli_o = yo_gecerli_q;
  assign bus.yo_kaynak_o  = yo_kaynak_q;
  assign bus.yo_veri_o    = yo_q.veri;
  assign bus.yo_adres_o   = yo_q.adres;
  assign bus.yo_etiket_o  = yo_q.etiket;

endmodule

// File: tb/tb_yazmac_yazma_hakemi.sv
// Scoreboard bench for the write arbiter: per-source expected queues plus timing checks.
module tb_yazmac_yazma_hakemi;
  import yazmac_yazma_hakemi_pkg::*;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  int   n_kontrol = 0;
  int   n_hata = 0;
  int   gy_sira = 0;

  yazma_girdisi_t gy_q[$];
  yazma_girdisi_t cb_q[$];

  yazmac_yazma_hakemi_if bus();

  yazmac_yazma_hakemi #(.ESIK(4)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen %0h beklenen %0h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic tik();
    @(posedge clk_i);
    #1;
  endtask

  task automatic gy_yukle();
    bus.gy_gecerli_i = 1'b1;
    bus.gy_veri_i    = 32'hA000_0000 + 32'(gy_sira);
    bus.gy_adres_i   = 5'(gy_sira % 31) + 5'd1;
    bus.gy_etiket_i  = 6'(gy_sira);
  endtask

  // Advance the pipeline entry only when it was accepted on this edge.
  task automatic tik_gy();
    logic durdu;
    logic sunuldu;
    durdu   = bus.boru_durdur_o;
    sunuldu = bus.gy_gecerli_i && (bus.gy_adres_i != 5'd0);
    tik();
    if (sunuldu && !durdu) begin
      gy_sira++;
      gy_yukle();
    end
  endtask

  task automatic cb_sur(input logic [4:0] adres, input logic [31:0] veri, input logic [5:0] etiket);
    bus.cb_gecerli_i = 1'b1;
    bus.cb_adres_i   = adres;
    bus.cb_veri_i    = veri;
    bus.cb_etiket_i  = etiket;
  endtask

  always @(negedge clk_i) begin
    yazma_girdisi_t e;
    if (bus.yo_gecerli_o) begin
      if (bus.yo_kaynak_o) begin
        if (cb_q.size() == 0) kontrol("cb_fazla_yazma", 64'd1, 64'd0);
        else begin
          e = cb_q.pop_front();
          kontrol("cb_veri", 64'(bus.yo_veri_o), 64'(e.veri));
          kontrol("cb_adres", 64'(bus.yo_adres_o), 64'(e.adres));
          kontrol("cb_etiket", 64'(bus.yo_etiket_o), 64'(e.etiket));
        end
      end else begin
        if (gy_q.size() == 0) kontrol("gy_fazla_yazma", 64'd1, 64'd0);
        else begin
          e = gy_q.pop_front();
          kontrol("gy_veri", 64'(bus.yo_veri_o), 64'(e.veri));
          kontrol("gy_adres", 64'(bus.yo_adres_o), 64'(e.adres));
          kontrol("gy_etiket", 64'(bus.yo_etiket_o), 64'(e.etiket));
        end
      end
    end
    if (rstn_i) begin
      if (bus.gy_gecerli_i && (bus.gy_adres_i != 5'd0) && !bus.boru_durdur_o)
        gy_q.push_back('{veri: bus.gy_veri_i, adres: bus.gy_adres_i, etiket: bus.gy_etiket_i});
      if (bus.cb_gecerli_i && bus.cb_hazir_o && (bus.cb_adres_i != 5'd0))
        cb_q.push_back('{veri: bus.cb_veri_i, adres: bus.cb_adres_i, etiket: bus.cb_etiket_i});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: zaman asimi");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.gy_gecerli_i = 1'b0; bus.gy_veri_i = '0; bus.gy_adres_i = '0; bus.gy_etiket_i = '0;
    bus.cb_gecerli_i = 1'b0; bus.cb_veri_i = '0; bus.cb_adres_i = '0; bus.cb_etiket_i = '0;

    // Reset state
    tik(); tik();
    kontrol("rst_yo_gecerli", 64'(bus.yo_gecerli_o), 64'd0);
    kontrol("rst_yo_veri", 64'(bus.yo_veri_o), 64'd0);
    kontrol("rst_yo_adres", 64'(bus.yo_adres_o), 64'd0);
    kontrol("rst_yo_etiket", 64'(bus.yo_etiket_o), 64'd0);
    kontrol("rst_yo_kaynak", 64'(bus.yo_kaynak_o), 64'd0);
    kontrol("rst_durdur", 64'(bus.boru_durdur_o), 64'd0);
    kontrol("rst_hazir", 64'(bus.cb_hazir_o), 64'd0);
    rstn_i = 1'b1;
    #1;
    kontrol("hazir_rst_sonrasi", 64'(bus.cb_hazir_o), 64'd1);

    // Pipeline only
    bus.gy_gecerli_i = 1'b1; bus.gy_adres_i = 5'd5; bus.gy_veri_i = 32'hDEADBEEF; bus.gy_etiket_i = 6'd3;
    tik();
    bus.gy_gecerli_i = 1'b0;
    kontrol("gy_yo_gecerli", 64'(bus.yo_gecerli_o), 64'd1);
    kontrol("gy_yo_adres", 64'(bus.yo_adres_o), 64'd5);
    kontrol("gy_yo_veri", 64'(bus.yo_veri_o), 64'hDEADBEEF);
    kontrol("gy_yo_kaynak", 64'(bus.yo_kaynak_o), 64'd0);
    kontrol("gy_hazir", 64'(bus.cb_hazir_o), 64'd1);
    tik();
    kontrol("gy_bosta", 64'(bus.yo_gecerli_o), 64'd0);

    // Idle pipeline, single cb result: two-edge latency
    cb_sur(5'd7, 32'h11, 6'd1);
    tik();
    bus.cb_gecerli_i = 1'b0;
    kontrol("cb_gecikme1", 64'(bus.yo_gecerli_o), 64'd0);
    tik();
    kontrol("cb_gecikme2", 64'(bus.yo_gecerli_o), 64'd1);
    kontrol("cb_adres7", 64'(bus.yo_adres_o), 64'd7);
    kontrol("cb_kaynak", 64'(bus.yo_kaynak_o), 64'd1);
    tik();
    kontrol("cb_bosaldi", 64'(bus.yo_gecerli_o), 64'd0);

    // Starvation: stall exactly one cycle, four edges after enqueue
    gy_yukle();
    cb_sur(5'd9, 32'h99, 6'd9);
    tik_gy();
    bus.cb_gecerli_i = 1'b0;
    kontrol("durdur_k0", 64'(bus.boru_durdur_o), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      tik_gy();
      kontrol($sformatf("durdur_k%0d", k), 64'(bus.boru_durdur_o), 64'(k == 4));
      if (k == 5) begin
        kontrol("durdur_cb_kaynak", 64'(bus.yo_kaynak_o), 64'd1);
        kontrol("durdur_cb_adres", 64'(bus.yo_adres_o), 64'd9);
      end
      if (k == 6) begin
        kontrol("durdur_gy_sonra", 64'(bus.yo_kaynak_o), 64'd0);
        kontrol("durdur_gy_gecerli", 64'(bus.yo_gecerli_o), 64'd1);
      end
    end
    bus.gy_gecerli_i = 1'b0;
    tik(); tik();

    // Full buffer
    gy_yukle();
    cb_sur(5'd10, 32'hA0A0, 6'd10);
    tik_gy();
    cb_sur(5'd11, 32'hB0B0, 6'd11);
    tik_gy();
    kontrol("dolu_hazir", 64'(bus.cb_hazir_o), 64'd0);
    cb_sur(5'd12, 32'hC0C0, 6'd12);
    tik_gy();
    kontrol("dolu_hazir_pop_oncesi", 64'(bus.cb_hazir_o), 64'd0);
    bus.cb_gecerli_i = 1'b0;
    bus.gy_gecerli_i = 1'b0;
    tik();
    kontrol("pop_sonrasi_hazir", 64'(bus.cb_hazir_o), 64'd1);
    kontrol("dolu_ilk_adres", 64'(bus.yo_adres_o), 64'd10);
    tik();
    kontrol("dolu_ikinci_adres", 64'(bus.yo_adres_o), 64'd11);
    tik();
    kontrol("dolu_bosaldi", 64'(bus.yo_gecerli_o), 64'd0);

    // x0 filtering
    gy_yukle();
    cb_sur(5'd13, 32'hD0D0, 6'd13);
    tik_gy();
    bus.cb_gecerli_i = 1'b0;
    bus.gy_gecerli_i = 1'b1; bus.gy_adres_i = 5'd0; bus.gy_veri_i = 32'h0BAD; bus.gy_etiket_i = 6'd0;
    tik();
    kontrol("x0_gy_bas_yazildi", 64'(bus.yo_gecerli_o), 64'd1);
    kontrol("x0_gy_kaynak", 64'(bus.yo_kaynak_o), 64'd1);
    kontrol("x0_gy_adres", 64'(bus.yo_adres_o), 64'd13);
    bus.gy_gecerli_i = 1'b0;
    cb_sur(5'd0, 32'h77, 6'd7);
    #1;
    kontrol("x0_cb_hazir", 64'(bus.cb_hazir_o), 64'd1);
    tik();
    bus.cb_gecerli_i = 1'b0;
    kontrol("x0_cb_yazma_yok1", 64'(bus.yo_gecerli_o), 64'd0);
    tik();
    kontrol("x0_cb_yazma_yok2", 64'(bus.yo_gecerli_o), 64'd0);

    // Mid-operation reset with full buffer and DURDUR
    gy_yukle();
    cb_sur(5'd14, 32'hE0E0, 6'd14);
    tik_gy();
    cb_sur(5'd15, 32'hF0F0, 6'd15);
    tik_gy();
    bus.cb_gecerli_i = 1'b0;
    for (int i = 0; i < 12 && !bus.boru_durdur_o; i++) tik_gy();
    kontrol("rst_oncesi_durdur", 64'(bus.boru_durdur_o), 64'd1);
    kontrol("rst_oncesi_dolu", 64'(bus.cb_hazir_o), 64'd0);
    rstn_i = 1'b0;
    bus.gy_gecerli_i = 1'b0;
    #1;
    kontrol("rst_sirasinda_hazir", 64'(bus.cb_hazir_o), 64'd0);
    tik();
    kontrol("rst2_yo_gecerli", 64'(bus.yo_gecerli_o), 64'd0);
    kontrol("rst2_yo_veri", 64'(bus.yo_veri_o), 64'd0);
    kontrol("rst2_yo_adres", 64'(bus.yo_adres_o), 64'd0);
    kontrol("rst2_yo_kaynak", 64'(bus.yo_kaynak_o), 64'd0);
    kontrol("rst2_durdur", 64'(bus.boru_durdur_o), 64'd0);
    kontrol("rst2_hazir", 64'(bus.cb_hazir_o), 64'd0);
    cb_q.delete();
    rstn_i = 1'b1;
    #1;
    kontrol("rst2_sonrasi_hazir", 64'(bus.cb_hazir_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tik();
      kontrol("rst2_eski_yazma_yok", 64'(bus.yo_gecerli_o), 64'd0);
    end

    kontrol("gy_kuyruk_bos", 64'(gy_q.size()), 64'd0);
    kontrol("cb_kuyruk_bos", 64'(cb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end

endmodule

// File: doc/yazmac_yazma_hakemi.md
# yazmac_yazma_hakemi

Arbitrates the single register-file write port between the in-order pipeline writeback stream and a multi-cycle execution unit (divider/multiplier) result stream. Multi-cycle results are held in a 2-entry buffer with valid/ready handshake; a starvation counter forces a one-cycle pipeline stall so buffered results always drain. Output is registered and drives the register file write port directly.

## Interface
- ESIK, 4: number of consecutive denied cycles of a non-empty buffer before a stall is forced; legal range 1..15.
- Widths come from shared macros: `VERI_BIT` (32), `YAZMAC_BIT` (5), `UOP_TAG_BIT`.
- clk_i  in  1  clock; all state changes on the rising edge.
- rstn_i  in  1  reset; synchronous, active-low.
- gy_gecerli_i  in  1  pipeline writeback valid; no backpressure except via boru_durdur_o.
- gy_veri_i  in  VERI_BIT  pipeline result.
- gy_adres_i  in  YAZMAC_BIT  pipeline destination register.
- gy_etiket_i  in  UOP_TAG_BIT  pipeline uop tag.
- cb_gecerli_i  in  1  multi-cycle unit result valid.
- cb_veri_i  in  VERI_BIT  multi-cycle result.
- cb_adres_i  in  YAZMAC_BIT  multi-cycle destination register.
- cb_etiket_i  in  UOP_TAG_BIT  multi-cycle uop tag.
- cb_hazir_o  out  1  buffer can accept; transfer when cb_gecerli_i && cb_hazir_o.
- boru_durdur_o  out  1  pipeline must hold its writeback entry this cycle.
- yo_gecerli_o  out  1  register file write enable.
- yo_veri_o  out  VERI_BIT  write data.
- yo_adres_o  out  YAZMAC_BIT  write address.
- yo_etiket_o  out  UOP_TAG_BIT  tag of the written uop.
- yo_kaynak_o  out  1  0 = pipeline, 1 = multi-cycle unit.

## Operation
- Buffer: 2-entry FIFO, count 0..2. cb_hazir_o = (count < 2) && rstn_i. No push when full, even with a same-cycle pop.
- x0 filtering: cb transfer with cb_adres_i == 0 is accepted (handshake completes) and discarded, never enqueued. Pipeline entry with gy_adres_i == 0 is treated as gy_gecerli_i = 0.
- States NORMAL and DURDUR. boru_durdur_o = (state == DURDUR).
- NORMAL grant:
  - Pipeline wins if gy valid (non-x0).
  - Otherwise, the buffer head wins if count > 0.
  - Otherwise, no grant.
- DURDUR grant: the buffer head always wins; the gy inputs are ignored. The pipeline re-presents the same entry next cycle.
- bekleme_sayac (4 bits):
  - Cleared when count == 0 or when the head is granted.
  - Otherwise incremented, saturating at 15.
- NORMAL -> DURDUR at the edge where count > 0, the head is not granted this cycle, and bekleme_sayac + 1 >= ESIK.
- DURDUR -> NORMAL unconditionally after one cycle; the head is granted in that cycle and the counter is cleared.
- A grant loads yo_* with the winner's fields and sets yo_gecerli_o = 1. With no grant, yo_gecerli_o = 0 and the data/address/tag hold their previous values.
- WAW ordering between the two sources is not enforced here. The upstream scoreboard guarantees that no two in-flight writes from different sources target the same register.

## Timing
- Reset (rstn_i low at an edge):
  - state = NORMAL, count = 0, bekleme_sayac = 0.
  - All yo_* = 0, yo_kaynak_o = 0, boru_durdur_o = 0.
  - cb_hazir_o = 0 while rstn_i is low.
  - Reset mid-operation drops buffered entries.
- Latency:
  - Pipeline input -> yo_* is 1 cycle.
  - Multi-cycle input -> yo_* is 2 cycles minimum: enqueue edge, then grant edge.
- Simultaneous push and pop with count 1: count stays 1, and the FIFO order is preserved.
- Pop at count 2 frees a slot; cb_hazir_o rises in the following cycle.
- Throughput: one register file write per cycle maximum. Worst-case head wait is ESIK + 1 cycles.

## Structure
- `VERI_BIT`, `YAZMAC_BIT`, `UOP_TAG_BIT`, `LOW`/`HIGH` come from sabitler.vh.
- The NORMAL/DURDUR state encoding is added to sabitler.vh for reuse by the hazard unit.
- Sub-module `yazma_tamponu`: 2-entry FIFO {veri, adres, etiket} with push/pop/count, synchronous active-low reset. The arbiter FSM, counter and output register stay in the top module.

## Test plan
- Pipeline only: gy valid, addr 5, data 0xDEADBEEF, tag 3 -> next cycle yo_gecerli_o=1, adres 5, veri 0xDEADBEEF, kaynak 0; cb_hazir_o stays 1.
- Idle pipeline: cb push addr 7, data 0x11 -> yo_gecerli_o=1, adres 7, kaynak 1 two edges after the push; count returns to 0.
- Starvation, ESIK=4: gy valid every cycle, one cb entry buffered -> boru_durdur_o=1 exactly one cycle, 4 cycles after enqueue. During it the buffered entry is written, and the held gy entry is written the next cycle. No write is lost or duplicated.
- Full buffer: two cb pushes while gy is busy -> cb_hazir_o=0, a third cb_gecerli_i is not accepted. After one pop, cb_hazir_o=1 on the next cycle.
- x0: gy addr 0 with a non-empty buffer -> the buffer head is written that cycle. A cb push with addr 0 -> handshake completes, count unchanged, no write.
- Mid-operation reset with count=2 and DURDUR active -> after one low edge, all outputs 0, cb_hazir_o=0 during reset and 1 after, no stale writes.
